itype_instr_gen: RTL and testbench

//  Synthesizable constrained-random RV32I I-type (OP-IMM) instruction source.

---
 rtl/itype_gen_pkg.sv | 30 +++
 rtl/lfsr32_galois.sv | 46 ++++
 rtl/itype_instr_gen.sv | 149 ++++++++++++++
 tb/tb_itype_instr_gen.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/itype_gen_pkg.sv
// Shared constants and types for the RV32I OP-IMM instruction generator.
//   OPC_OP_IMM : major opcode of every generated word
//   NOP        : canonical ADDI x0,x0,0 presented whenever no word is valid
//   LFSR_TAPS  : Galois feedback mask for the 32-bit stimulus LFSR
//   funct3_e   : OP-IMM funct3 encodings
//   state_e    : generator control states
package itype_gen_pkg;

    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [31:0] NOP        = 32'h00000013;
    localparam logic [31:0] LFSR_TAPS  = 32'h80200003;

    typedef enum logic [2:0] {
        ADDI  = 3'd0,
        SLLI  = 3'd1,
        SLTI  = 3'd2,
        SLTIU = 3'd3,
        XORI  = 3'd4,
        SRXI  = 3'd5,
        ORI   = 3'd6,
        ANDI  = 3'd7
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR with synchronous reset, parallel load and step enable.
//   clk      : clock
//   reset    : synchronous active-high; q returns to SEED (0 -> 1)
//   load     : load load_val (0 -> 1); has priority over step
//   load_val : value to load
//   step     : advance one position
//   q        : current LFSR state
module lfsr32_galois
    import itype_gen_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h000000BB
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        step,
    output logic [31:0] q
);

    // An all-zero state would lock the LFSR, so zero seeds are replaced by 1.
    localparam logic [31:0] SEED_SAFE = (SEED == 32'd0) ? 32'd1 : SEED;

    logic [31:0] q_q;
    logic [31:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = (load_val == 32'd0) ? 32'd1 : load_val;
        end else if (step) begin
            q_d = (q_q >> 1) ^ (q_q[0] ? LFSR_TAPS : 32'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= SEED_SAFE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/itype_instr_gen.sv
// Constrained-random RV32I OP-IMM instruction source with valid/ready output.
//   clk         : clock
//   reset       : synchronous active-high
//   en          : start generation (sampled in IDLE only)
//   seed_load   : in IDLE, reload the LFSR from seed_in (wins over en)
//   seed_in     : runtime seed
//   instr_ready : consumer accepts instr this cycle
//   instr_valid : instr holds a generated word
//   instr       : instruction word, NOP when not valid
//   instr_count : completed handshakes since reset
//   done        : sticky, NUM_INSTR handshakes completed
module itype_instr_gen
    import itype_gen_pkg::*;
#(
    parameter logic [31:0] SEED        = 32'h000000BB,
    parameter int unsigned NUM_INSTR   = 100,
    parameter logic [7:0]  FUNCT3_MASK = 8'hFF,
    parameter bit          ALLOW_RD0   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        seed_load,
    input  logic [31:0] seed_in,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_count,
    output logic        done
);

    // Slice the LFSR into fields and apply the legality fixups.
    function automatic logic [31:0] make_instr(input logic [31:0] l);
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [2:0]  f3;
        logic [4:0]  rd;
        imm = l[31:20];
        rs1 = l[19:15];
        f3  = l[14:12];
        rd  = l[11:7];
        if (!FUNCT3_MASK[f3]) begin
            f3 = ADDI;
        end
        // Shift-immediate forms: shamt in [4:0], bit 10 selects SRAI.
        if (f3 == SLLI) begin
            imm &= 12'h01F;
        end else if (f3 == SRXI) begin
            imm &= 12'h41F;
        end
        if (!ALLOW_RD0 && rd == 5'd0) begin
            rd = 5'd1;
        end
        return {imm, rs1, f3, rd, OPC_OP_IMM};
    endfunction

    state_e      state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] count_q, count_d;
    logic        done_q, done_d;

    logic        gen;
    logic        lfsr_load;
    logic [31:0] lfsr_q;
    logic [31:0] gen_word;
    logic        handshake;

    lfsr32_galois #(
        .SEED(SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (lfsr_load),
        .load_val (seed_in),
        .step     (gen),
        .q        (lfsr_q)
    );

    assign gen_word  = make_instr(lfsr_q);
    assign handshake = valid_q & instr_ready;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        done_d    = done_q;
        gen       = 1'b0;
        lfsr_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (seed_load) begin
                    lfsr_load = 1'b1;
                end else if (en) begin
                    gen     = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (handshake) begin
                    count_d = count_q + 32'd1;
                    if (NUM_INSTR != 32'd0 && count_d == 32'(NUM_INSTR)) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        gen = 1'b1;
                    end
                end
            end
            DONE: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A stalled word is held; outside RUN the bus shows NOP.
        valid_d = (state_d == RUN);
        if (gen) begin
            instr_d = gen_word;
        end else if (state_d == RUN) begin
            instr_d = instr_q;
        end else begin
            instr_d = NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            instr_q <= NOP;
            count_q <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_count = count_q;
    assign done        = done_q;

endmodule

// File: tb/tb_itype_instr_gen.sv
// Scoreboard bench for itype_instr_gen: three instances with different parameters.
//   a: defaults (SEED BB, 100 instrs, all funct3, rd0 allowed)
//   b: NUM_INSTR=4
//   c: unbounded, ADDI only, rd0 forbidden
module tb_itype_instr_gen;

    localparam logic [31:0] NOP_W = 32'h00000013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_reset, a_en, a_seed_load, a_ready, a_valid, a_done;
    logic [31:0] a_seed_in, a_instr, a_count;
    logic        b_reset, b_en, b_seed_load, b_ready, b_valid, b_done;
    logic [31:0] b_seed_in, b_instr, b_count;
    logic        c_reset, c_en, c_seed_load, c_ready, c_valid, c_done;
    logic [31:0] c_seed_in, c_instr, c_count;

    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    logic [31:0] exp_c[$];

    itype_instr_gen dut_a (
        .clk(clk), .reset(a_reset), .en(a_en), .seed_load(a_seed_load), .seed_in(a_seed_in),
        .instr_ready(a_ready), .instr_valid(a_valid), .instr(a_instr),
        .instr_count(a_count), .done(a_done)
    );

    itype_instr_gen #(
        .NUM_INSTR(4)
    ) dut_b (
        .clk(clk), .reset(b_reset), .en(b_en), .seed_load(b_seed_load), .seed_in(b_seed_in),
        .instr_ready(b_ready), .instr_valid(b_valid), .instr(b_instr),
        .instr_count(b_count), .done(b_done)
    );

    itype_instr_gen #(
        .NUM_INSTR(0),
        .FUNCT3_MASK(8'h01),
        .ALLOW_RD0(1'b0)
    ) dut_c (
        .clk(clk), .reset(c_reset), .en(c_en), .seed_load(c_seed_load), .seed_in(c_seed_in),
        .instr_ready(c_ready), .instr_valid(c_valid), .instr(c_instr),
        .instr_count(c_count), .done(c_done)
    );

    // Reference: shift right, fold the taps back in when a 1 drops out.
    function automatic logic [31:0] ref_next(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
    endfunction

    // Reference: field extraction and fixups written as plain arithmetic.
    function automatic logic [31:0] ref_word(input logic [31:0] l, input logic [7:0] mask,
                                             input bit rd0);
        int unsigned v, imm, rs1, f3, rd;
        v   = l;
        imm = v / 1048576;
        rs1 = (v / 32768) % 32;
        f3  = (v / 4096) % 8;
        rd  = (v / 128) % 32;
        if (mask[f3] == 1'b0) f3 = 0;
        if (f3 == 1) imm = imm % 32;
        else if (f3 == 5) imm = (imm % 32) + ((imm / 1024) % 2) * 1024;
        if (!rd0 && rd == 0) rd = 1;
        return 32'(imm * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 19);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Push n expected words starting from the seed the DUT will hold.
    task automatic fill(input int which, input logic [31:0] seed, input int n,
                        input logic [7:0] mask, input bit rd0);
        logic [31:0] l;
        l = (seed == 32'd0) ? 32'd1 : seed;
        for (int i = 0; i < n; i++) begin
            case (which)
                0:       exp_a.push_back(ref_word(l, mask, rd0));
                1:       exp_b.push_back(ref_word(l, mask, rd0));
                default: exp_c.push_back(ref_word(l, mask, rd0));
            endcase
            l = ref_next(l);
        end
    endtask

    // Monitors: one pop per handshake the DUT will take at the next edge.
    always @(negedge clk) begin
        if (!a_reset && a_valid && a_ready) begin
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL a_underflow: got %h expected none", a_instr);
            end else begin
                check("a_stream", a_instr, exp_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!b_reset && b_valid && b_ready) begin
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL b_underflow: got %h expected none", b_instr);
            end else begin
                check("b_stream", b_instr, exp_b.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!c_reset && c_valid && c_ready) begin
            if (exp_c.size() == 0) begin
                errors++;
                $display("FAIL c_underflow: got %h expected none", c_instr);
            end else begin
                check("c_stream", c_instr, exp_c.pop_front());
            end
            check("c_funct3_addi", 32'(c_instr[14:12]), 32'd0);
            check("c_rd_nonzero", 32'(c_instr[11:7] != 5'd0), 32'd1);
            check("c_shift_imm", 32'(!((c_instr[14:12] == 3'd1 && c_instr[31:25] != 7'd0) ||
                  (c_instr[14:12] == 3'd5 && (c_instr[31:20] & ~12'h41F) != 12'd0))), 32'd1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[7];
        logic [31:0] w[4];
        logic [31:0] l;
        int k, hs, cyc;
        logic [31:0] s;

        {a_en, a_seed_load, a_ready, a_seed_in} = '0;
        {b_en, b_seed_load, b_ready, b_seed_in} = '0;
        {c_en, c_seed_load, c_ready, c_seed_in} = '0;
        a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;

        // T1: held in reset
        repeat (3) begin
            @(negedge clk);
            check("t1_instr", a_instr, NOP_W);
            check("t1_valid", 32'(a_valid), 32'd0);
            check("t1_count", a_count, 32'd0);
            check("t1_done", 32'(a_done), 32'd0);
        end
        @(posedge clk); #1;
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;

        // T2: runtime seed, full throughput to done
        a_seed_load = 1'b1; a_seed_in = 32'h12345093;
        @(posedge clk); #1;
        a_seed_load = 1'b0;
        fill(0, 32'h12345093, 100, 8'hFF, 1'b1);
        a_en = 1'b1; a_ready = 1'b1;
        @(negedge clk);
        check("t2_valid_before_en", 32'(a_valid), 32'd0);
        @(posedge clk); #1;
        a_en = 1'b0;
        @(negedge clk);
        check("t2_latency_valid", 32'(a_valid), 32'd1);
        check("t2_first", a_instr, 32'h00345093);
        @(negedge clk);
        check("t2_second", a_instr, ref_word(32'h893A284A, 8'hFF, 1'b1));
        cyc = 0;
        while (!a_done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("t2_done", 32'(a_done), 32'd1);
        check("t2_count", a_count, 32'd100);
        check("t2_valid_after", 32'(a_valid), 32'd0);
        check("t2_instr_after", a_instr, NOP_W);
        check("t2_queue_empty", 32'(exp_a.size()), 32'd0);

        // T6: reset while stalled, then replay from SEED
        @(posedge clk); #1;
        a_reset = 1'b1; a_ready = 1'b0;
        @(posedge clk); #1;
        a_reset = 1'b0; a_en = 1'b1;
        @(posedge clk); #1;
        a_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t6_stall_valid", 32'(a_valid), 32'd1);
            check("t6_stall_instr", a_instr, ref_word(32'h000000BB, 8'hFF, 1'b1));
        end
        @(posedge clk); #1;
        a_reset = 1'b1;
        @(posedge clk); #1;
        a_reset = 1'b0;
        @(negedge clk);
        check("t6_valid", 32'(a_valid), 32'd0);
        check("t6_count", a_count, 32'd0);
        check("t6_instr", a_instr, NOP_W);
        fill(0, 32'h000000BB, 5, 8'hFF, 1'b1);
        @(posedge clk); #1;
        a_en = 1'b1; a_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        a_en = 1'b0; a_ready = 1'b0;
        @(negedge clk);
        check("t6_replay_count", a_count, 32'd5);
        check("t6_queue_empty", 32'(exp_a.size()), 32'd0);

        // T5: NUM_INSTR=4 with back-pressure
        seq = '{1, 0, 0, 1, 1, 0, 1};
        l = 32'h000000BB;
        for (int i = 0; i < 4; i++) begin
            w[i] = ref_word(l, 8'hFF, 1'b1);
            l = ref_next(l);
        end
        fill(1, 32'h000000BB, 4, 8'hFF, 1'b1);
        b_en = 1'b1;
        @(posedge clk); #1;
        b_en = 1'b0;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            b_ready = seq[i][0];
            @(negedge clk);
            check("t5_valid", 32'(b_valid), 32'd1);
            check("t5_instr", b_instr, w[k]);
            check("t5_count", b_count, 32'(k));
            check("t5_done_early", 32'(b_done), 32'd0);
            if (seq[i] != 0) k++;
            @(posedge clk); #1;
        end
        b_ready = 1'b0;
        @(negedge clk);
        check("t5_done", 32'(b_done), 32'd1);
        check("t5_valid_after", 32'(b_valid), 32'd0);
        check("t5_instr_after", b_instr, NOP_W);
        check("t5_count_final", b_count, 32'd4);
        @(posedge clk); #1;
        b_en = 1'b1; b_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        b_en = 1'b0; b_ready = 1'b0;
        @(negedge clk);
        check("t5_done_sticky", 32'(b_done), 32'd1);
        check("t5_valid_sticky", 32'(b_valid), 32'd0);
        check("t5_count_sticky", b_count, 32'd4);

        // T3: zero seed behaves as seed 1; en ignored on the load cycle
        fill(2, 32'h00000001, 20, 8'h01, 1'b0);
        c_seed_load = 1'b1; c_seed_in = 32'd0; c_en = 1'b1; c_ready = 1'b1;
        @(posedge clk); #1;
        c_seed_load = 1'b0;
        @(negedge clk);
        check("t3_en_ignored_on_load", 32'(c_valid), 32'd0);
        @(posedge clk); #1;
        c_en = 1'b0;
        @(negedge clk);
        check("t3_first", c_instr, 32'h00000093);
        repeat (20) @(posedge clk);
        #1;
        c_ready = 1'b0;
        @(negedge clk);
        check("t3_count", c_count, 32'd20);
        check("t3_queue_empty", 32'(exp_c.size()), 32'd0);
        @(posedge clk); #1;
        c_reset = 1'b1;
        @(posedge clk); #1;
        c_reset = 1'b0;

        // T4: 1000 constrained words under random back-pressure
        s = $urandom;
        fill(2, s, 1000, 8'h01, 1'b0);
        c_seed_load = 1'b1; c_seed_in = s;
        @(posedge clk); #1;
        c_seed_load = 1'b0; c_en = 1'b1; c_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
        c_en = 1'b0;
        hs = 0;
        cyc = 0;
        while (hs < 1000 && cyc < 5000) begin
            @(negedge clk);
            if (c_valid && c_ready) hs++;
            @(posedge clk); #1;
            cyc++;
            c_ready = (hs < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
        end
        @(negedge clk);
        check("t4_handshakes", 32'(hs), 32'd1000);
        check("t4_count", c_count, 32'd1000);
        check("t4_queue_empty", 32'(exp_c.size()), 32'd0);
        check("t4_done_unbounded", 32'(c_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
